// File: rtl/instr_imm_packer.sv
// Packs a two's-complement immediate into RISC-V I/S/B/J instruction bit positions and flags immediates that do not fit.
// Latency: 1 clock from accept to out_valid, through a single registered output stage.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while out_ready is low. Optional INSTR_IMM_PACKER_SELFCHECK_EN adds chk_mismatch.
module instr_imm_packer #(
   parameter int ADDR_W   = 12,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          src,
   input  logic [31:0]         imm,
   input  logic [31:0]         base,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_cnt
`ifdef INSTR_IMM_PACKER_SELFCHECK_EN
   ,
   output logic                chk_mismatch
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [1:0] SRC_I = 2'b00;
   localparam logic [1:0] SRC_S = 2'b01;
   localparam logic [1:0] SRC_B = 2'b10;
   localparam logic [1:0] SRC_J = 2'b11;

   state_t                state_q, state_d;
   logic [31:0]           instr_q, instr_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  err_q, err_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;
   logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic                  accept;
   logic                  hs;
   logic [31:0]           packed_word;
   logic                  range_err;

   // The top immediate field bits are always overwritten, so base[31:25] never reaches the output.
   logic unused_base;
   assign unused_base = ^base[31:25];

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign hs        = out_valid && out_ready;
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign out_err   = err_q;
   assign err_cnt   = err_cnt_q;

   // Scatter the immediate into the selected format and check that it fits.
   always_comb begin
      packed_word = base;
      range_err   = 1'b0;
      unique case (src)
         SRC_I: begin
            packed_word = {imm[11:0], base[19:0]};
            range_err   = (|imm[31:11]) && !(&imm[31:11]);
         end
         SRC_S: begin
            packed_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            range_err   = (|imm[31:11]) && !(&imm[31:11]);
         end
         SRC_B: begin
            packed_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            range_err   = ((|imm[31:12]) && !(&imm[31:12])) || imm[0];
         end
         SRC_J: begin
            packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            range_err   = ((|imm[31:20]) && !(&imm[31:20])) || imm[0];
         end
         default: begin
            packed_word = base;
            range_err   = 1'b0;
         end
      endcase
   end

   // Next-state for the output stage, address counter and error counter.
   // An item accepted on the same edge as a handshake takes the post-increment address.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;

      if (hs) begin
         cnt_d = cnt_q + ADDR_W'(4);
         if (err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
         end
      end
      if (clr) begin
         cnt_d     = '0;
         err_cnt_d = '0;
      end

      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (hs && !accept) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         instr_d = packed_word;
         err_d   = range_err;
         addr_d  = cnt_d;
      end
   end

   // State and datapath registers; reset discards any held word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         instr_q   <= '0;
         addr_q    <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

`ifdef INSTR_IMM_PACKER_SELFCHECK_EN
   logic [31:0] imm_q, imm_d;
   logic [1:0]  src_q, src_d;
   logic [31:0] dec_imm;

   // Keep a copy of the original immediate and format alongside the output word.
   always_comb begin
      imm_d = imm_q;
      src_d = src_q;
      if (accept) begin
         imm_d = imm;
         src_d = src;
      end
   end

   // Shadow registers for the re-decode check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_q <= '0;
         src_q <= '0;
      end else begin
         imm_q <= imm_d;
         src_q <= src_d;
      end
   end

   // Re-decode the held word with the sign-extend rules and compare to the original immediate.
   always_comb begin
      dec_imm = '0;
      unique case (src_q)
         SRC_I:   dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
         SRC_S:   dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         SRC_B:   dec_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                             instr_q[11:8], 1'b0};
         SRC_J:   dec_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                             instr_q[30:21], 1'b0};
         default: dec_imm = '0;
      endcase
   end

   assign chk_mismatch = out_valid && !err_q && (dec_imm != imm_q);
`endif

endmodule

// File: tb/tb_instr_imm_packer.sv
module tb_instr_imm_packer;

   localparam int ADDR_W   = 12;
   localparam int ERRCNT_W = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                clr;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          src;
   logic [31:0]         imm;
   logic [31:0]         base;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_instr;
   logic [ADDR_W-1:0]   out_addr;
   logic                out_err;
   logic [ERRCNT_W-1:0] err_cnt;
`ifdef INSTR_IMM_PACKER_SELFCHECK_EN
   logic                chk_mismatch;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [ADDR_W-1:0] exp_addr;

   instr_imm_packer #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .src(src), .imm(imm), .base(base),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_cnt(err_cnt)
`ifdef INSTR_IMM_PACKER_SELFCHECK_EN
      , .chk_mismatch(chk_mismatch)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] i, input logic [31:0] b);
      in_valid = v;
      src      = s;
      imm      = i;
      base     = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
`ifdef INSTR_IMM_PACKER_SELFCHECK_EN
      check("chk_mismatch", {31'd0, chk_mismatch}, 32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_addr", {20'd0, out_addr}, 32'h0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      rst = 1'b0;

      // 1: I format, -1
      drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0013);
      step();
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_instr", out_instr, 32'hFFF0_0013);
      check("t1_err", {31'd0, out_err}, 32'd0);
      check("t1_addr", {20'd0, out_addr}, 32'h000);
      // drain with clr on the handshake edge: clr beats the increment
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t1_drain_valid", {31'd0, out_valid}, 32'd0);

      // 2: S then B back-to-back
      drive(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0000_2023);
      step();
      check("t2s_instr", out_instr, 32'hFE00_2E23);
      check("t2s_addr", {20'd0, out_addr}, 32'h000);
      check("t2s_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 2'b10, 32'hFFFF_FFF8, 32'h0000_0063);
      step();
      check("t2b_instr", out_instr, 32'hFE00_0CE3);
      check("t2b_addr", {20'd0, out_addr}, 32'h004);
      check("t2b_in_ready", {31'd0, in_ready}, 32'd1);

      // 3: J format, +2048
      drive(1'b1, 2'b11, 32'h0000_0800, 32'h0000_006F);
      step();
      check("t3_instr", out_instr, 32'h0010_006F);
      check("t3_err", {31'd0, out_err}, 32'd0);
      check("t3_addr", {20'd0, out_addr}, 32'h008);

      // 4: out-of-range items are still emitted, and counted on handshake
      drive(1'b1, 2'b10, 32'h0000_0003, 32'h0000_0063);
      step();
      check("t4b_err", {31'd0, out_err}, 32'd1);
      check("t4b_instr", out_instr, 32'h0000_0163);
      check("t4b_addr", {20'd0, out_addr}, 32'h00C);
      drive(1'b1, 2'b00, 32'h0000_0800, 32'h0000_0013);
      step();
      check("t4i_err", {31'd0, out_err}, 32'd1);
      check("t4i_instr", out_instr, 32'h8000_0013);
      check("t4i_err_cnt1", {24'd0, err_cnt}, 32'd1);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      step();
      check("t4_err_cnt2", {24'd0, err_cnt}, 32'd2);
      check("t4_empty", {31'd0, out_valid}, 32'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_clr_err_cnt", {24'd0, err_cnt}, 32'd0);
      drive(1'b1, 2'b00, 32'h0000_0005, 32'h0000_0013);
      step();
      check("t4_post_clr_addr", {20'd0, out_addr}, 32'h000);
      check("t4_post_clr_instr", out_instr, 32'h0050_0013);

      // 5: backpressure for 3 cycles with a pending input
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 32'h0000_0007, 32'h0000_0013);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("t5_in_ready", {31'd0, in_ready}, 32'd0);
         step();
         check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
         check("t5_hold_instr", out_instr, 32'h0050_0013);
         check("t5_hold_addr", {20'd0, out_addr}, 32'h000);
         check("t5_hold_err", {31'd0, out_err}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      check("t5_next_instr", out_instr, 32'h0070_0013);
      check("t5_next_addr", {20'd0, out_addr}, 32'h004);

      // 5b: stream until the address counter wraps
      drive(1'b1, 2'b00, 32'h0, 32'h0000_0013);
      exp_addr = 12'h008;
      for (int k = 0; k < 1023; k++) begin
         step();
         check("t5_stream_addr", {20'd0, out_addr}, {20'd0, exp_addr});
         exp_addr = exp_addr + 12'h004;
      end
      check("t5_wrap_addr", {20'd0, out_addr}, 32'h000);
      check("t5_wrap_err_cnt", {24'd0, err_cnt}, 32'd0);

      // 6: asynchronous reset while full and stalled
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      out_ready = 1'b0;
      step();
      check("t6_full", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_valid", {31'd0, out_valid}, 32'd0);
      check("t6_async_instr", out_instr, 32'h0);
      #2;
      rst = 1'b0;
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("t6_stay_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 2'b01, 32'h0000_0001, 32'h0000_2023);
      step();
      check("t6_restart_addr", {20'd0, out_addr}, 32'h000);
      check("t6_restart_instr", out_instr, 32'h0000_20A3);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_imm_packer.md
Name: instr_imm_packer

Overview:
- Inverse of the immediate sign-extender. It accepts a base instruction word, a 32-bit immediate and a format select, then scatters the immediate bits into RISC-V I/S/B/J bit positions.
- Range-checks the immediate against the chosen format.
- Emits the finished instruction through a registered valid/ready stage, tagged with a sequential byte address.
- Used by the program loader / self-test path to build instruction memory images in-system.

Parameters:
- ADDR_W, 12, width of the output address counter (byte address, wraps at 2^ADDR_W).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of address counter and error counter.
- in_valid  in  1  input item valid.
- in_ready  out  1  packer can accept an item this cycle.
- src  in  2  format select: 00 I, 01 S, 10 B, 11 J.
- imm  in  32  immediate, two's complement.
- base  in  32  instruction word whose non-immediate fields are kept; immediate fields are overwritten.
- out_valid  out  1  out_instr/out_addr/out_err valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_W  byte address assigned to out_instr.
- out_err  out  1  immediate of this item was out of range or misaligned.
- err_cnt  out  ERRCNT_W  count of emitted items with out_err=1, saturating.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_cnt=0, internal address counter=0.
- Single output register stage with two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid | out_ready. This is combinational and allows full throughput of one item per cycle.
- Accept occurs when in_valid & in_ready.
  - Next cycle: out_valid=1, out_instr=packed word, out_err=range flag, out_addr=address counter value.
  - Latency is 1 clock.
- Output handshake occurs when out_valid & out_ready.
  - Address counter += 4, wrapping modulo 2^ADDR_W.
  - If out_err=1, err_cnt += 1, saturating at all-ones.
  - With no simultaneous accept, go to EMPTY.
- While out_valid=1 & out_ready=0: out_instr, out_addr and out_err are held stable. in_ready=0.
- Packing (all bits not listed come from base):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. imm[0] is dropped.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. imm[0] is dropped.
- Range flag is set when the immediate does not fit its format:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - An erroneous item is still emitted, with truncated bits and out_err=1. It is never dropped.
- clr (synchronous):
  - Address counter=0 and err_cnt=0. clr wins over a simultaneous handshake increment.
  - A word already held in the output register keeps its out_addr.
  - clr does not affect out_valid.
- Reset during FULL: output is discarded immediately. Nothing is emitted after reset deasserts until a new accept.

Optional Feature:
- INSTR_IMM_PACKER_SELFCHECK_EN. When defined, the block re-decodes the registered out_instr using the sign-extend rules for src.
  - Adds output port chk_mismatch (1 bit).
  - chk_mismatch = out_valid & !out_err & (decoded immediate != stored imm).
  - A stored copy of imm/src is held with the output register.
  - chk_mismatch must never be 1 in a correct design.
- When undefined: no extra port, no extra registers.

Test Plan:
1. I: base=0x00000013, imm=0xFFFFFFFF, src=00, out_ready=1 -> next cycle out_instr=0xFFF00013, out_err=0, out_addr=0x000.
2. S then B back-to-back, out_ready=1:
   - S: base=0x00002023, imm=0xFFFFFFFC, src=01 -> out_instr=0xFE002E23, out_addr=0x000.
   - B: base=0x00000063, imm=0xFFFFFFF8, src=10 -> out_instr=0xFE000CE3, out_addr=0x004.
   - in_ready stays 1 throughout.
3. J: base=0x0000006F, imm=0x00000800, src=11 -> out_instr=0x0010006F, out_err=0.
4. Errors:
   - B with imm=0x00000003 -> out_err=1, err_cnt=1 after handshake.
   - I with imm=0x00000800 -> out_err=1, err_cnt=2.
   - Pulse clr -> err_cnt=0, next out_addr=0x000.
5. Backpressure: hold out_ready=0 for 3 cycles after one accept.
   - in_ready=0 and outputs stable.
   - Then out_ready=1 -> the address advances only once per handshake.
   - Counter wraps from 0xFFC to 0x000 (ADDR_W=12).
6. Assert rst while FULL with out_ready=0 -> out_valid=0 immediately (asynchronous). After release, in_ready=1 and address restarts at 0x000.
